// File: rtl/image_frame_scheduler_if.sv
// Command and pixel handshake bundle for image_frame_scheduler.
// The master side is the command source / pixel sink; the slave side is the scheduler.
interface image_frame_scheduler_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        cmd_sign;
  logic [7:0]  cmd_value;
  logic [7:0]  cmd_thresh;
  logic        pix_ready;
  logic        pix_valid;
  logic [20:0] pix_addr;
  logic [9:0]  pix_row;
  logic [10:0] pix_col;
  logic        HSYNC;
  logic        line_end;

  modport master (
    output cmd_valid, cmd_op, cmd_sign, cmd_value, cmd_thresh, pix_ready,
    input  cmd_ready, pix_valid, pix_addr, pix_row, pix_col, HSYNC, line_end
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_sign, cmd_value, cmd_thresh, pix_ready,
    output cmd_ready, pix_valid, pix_addr, pix_row, pix_col, HSYNC, line_end
  );
endinterface

// File: rtl/image_frame_scheduler.sv
// image_frame_scheduler: queues operation commands and, per command, runs one
// bottom-up (BMP order) raster scan of an RGB888 image, emitting per-pixel byte
// addresses, line/frame markers and a frame-stable operation configuration.
module image_frame_scheduler #(
  parameter int WIDTH      = 768,
  parameter int HEIGHT     = 512,
  parameter int HBLANK     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   abort,
  image_frame_scheduler_if.slave bus,
  output logic                   frame_start,
  output logic                   frame_done,
  output logic [1:0]             op_mode,
  output logic                   op_sign,
  output logic [7:0]             op_value,
  output logic [7:0]             op_thresh,
  output logic                   busy,
  output logic [15:0]            frame_count
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int HB_W = (HBLANK > 1) ? $clog2(HBLANK) : 1;
  localparam logic [10:0]     COL_LAST = 11'(WIDTH - 1);
  localparam logic [9:0]      ROW_LAST = 10'(HEIGHT - 1);
  localparam logic [HB_W-1:0] HB_LAST  = HB_W'((HBLANK > 0) ? HBLANK - 1 : 0);

  typedef struct packed {
    logic [1:0] op;
    logic       sign;
    logic [7:0] value;
    logic [7:0] thresh;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LINE, S_HBLANK, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [9:0]      row_q, row_d;
  logic [10:0]     col_q, col_d;
  logic [HB_W-1:0] hb_q, hb_d;
  logic [15:0]     fc_q, fc_d;
  cmd_t            op_q, op_d;
  cmd_t            mem_q [FIFO_DEPTH];
  cmd_t            mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic  full, empty, push, pop, pix_valid;
  cmd_t  cmd_in, head;
  logic [31:0] lin_idx;

  assign full   = (cnt_q == CW'(FIFO_DEPTH));
  assign empty  = (cnt_q == '0);
  assign push   = bus.cmd_valid && !full;
  assign cmd_in = '{op: bus.cmd_op, sign: bus.cmd_sign, value: bus.cmd_value, thresh: bus.cmd_thresh};
  assign head   = mem_q[rd_q];

  // Command FIFO bookkeeping; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q] = cmd_in;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  // Frame FSM: next state, scan counters, config latch and per-state strobes.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    hb_d        = hb_q;
    fc_d        = fc_q;
    op_d        = op_q;
    pop         = 1'b0;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    pix_valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The pop and config latch share the edge that enters LOAD, so the
        // new configuration is already visible while frame_start is high.
        if (!empty) begin
          state_d = S_LOAD;
          pop     = 1'b1;
          op_d    = head;
        end
      end
      S_LOAD: begin
        frame_start = 1'b1;
        row_d       = '0;
        col_d       = '0;
        state_d     = S_LINE;
      end
      S_LINE: begin
        pix_valid = 1'b1;
        if (bus.pix_ready) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = S_DONE;
            end else begin
              row_d   = row_q + 10'd1;
              hb_d    = '0;
              state_d = (HBLANK == 0) ? S_LINE : S_HBLANK;
            end
          end else begin
            col_d = col_q + 11'd1;
          end
        end
      end
      S_HBLANK: begin
        if (hb_q == HB_LAST) state_d = S_LINE;
        else                 hb_d    = hb_q + HB_W'(1);
      end
      S_DONE: begin
        frame_done = 1'b1;
        fc_d       = fc_q + 16'd1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort beats everything, including the final pixel accept and DONE.
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      row_d      = '0;
      col_d      = '0;
      hb_d       = '0;
      fc_d       = fc_q;
      frame_done = 1'b0;
    end
  end

  // Linear pixel index in bottom-up storage order; address is 3 bytes per pixel.
  always_comb begin
    lin_idx = (32'(ROW_LAST) - 32'(row_q)) * 32'(WIDTH) + 32'(col_q);
  end

  assign bus.cmd_ready = !full;
  assign bus.pix_valid = pix_valid;
  assign bus.HSYNC     = pix_valid;
  assign bus.pix_addr  = pix_valid ? 21'(lin_idx * 32'd3) : '0;
  assign bus.pix_row   = pix_valid ? row_q : '0;
  assign bus.pix_col   = pix_valid ? col_q : '0;
  assign bus.line_end  = pix_valid && (col_q == COL_LAST);
  assign busy          = (state_q != S_IDLE);
  assign frame_count   = fc_q;
  assign op_mode       = op_q.op;
  assign op_sign       = op_q.sign;
  assign op_value      = op_q.value;
  assign op_thresh     = op_q.thresh;

  // State registers; reset also flushes the command queue.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      hb_q    <= '0;
      fc_q    <= '0;
      op_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      hb_q    <= hb_d;
      fc_q    <= fc_d;
      op_q    <= op_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end
endmodule

// File: tb/tb_image_frame_scheduler.sv
// Scoreboard bench for image_frame_scheduler: accepted commands queue expected
// frames; a monitor derives every pixel from (frame, pixel index) arithmetic.
module tb_image_frame_scheduler;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int HB = 2;
  localparam int D  = 4;

  typedef struct packed {
    logic [1:0] op;
    logic       sign;
    logic [7:0] value;
    logic [7:0] thresh;
  } cmd_t;

  logic HCLK, HRESETn;
  logic abort, abort_dir, abort_rnd, abort2;
  logic frame_start, frame_done, op_sign, busy;
  logic [1:0] op_mode;
  logic [7:0] op_value, op_thresh;
  logic [15:0] frame_count;
  logic fs2, fd2, os2, busy2;
  logic [1:0] om2;
  logic [7:0] ov2, ot2;
  logic [15:0] fc2;

  image_frame_scheduler_if bus ();
  image_frame_scheduler_if bus2 ();

  assign abort = abort_dir | abort_rnd;

  image_frame_scheduler #(.WIDTH(W), .HEIGHT(H), .HBLANK(HB), .FIFO_DEPTH(D)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .abort(abort), .bus(bus),
    .frame_start(frame_start), .frame_done(frame_done), .op_mode(op_mode),
    .op_sign(op_sign), .op_value(op_value), .op_thresh(op_thresh),
    .busy(busy), .frame_count(frame_count)
  );

  image_frame_scheduler #(.WIDTH(2), .HEIGHT(2), .HBLANK(0), .FIFO_DEPTH(2)) u_dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .abort(abort2), .bus(bus2),
    .frame_start(fs2), .frame_done(fd2), .op_mode(om2),
    .op_sign(os2), .op_value(ov2), .op_thresh(ot2),
    .busy(busy2), .frame_count(fc2)
  );

  int n_checks = 0;
  int n_errors = 0;
  cmd_t exp_q[$];
  int   rdy_mode = 0;
  bit   rand_abort_en = 0;
  // monitor model state
  bit   active = 0, load = 0, done_next = 0, prev_stall = 0;
  int   k = 0, gap_left = 0;
  logic [15:0] exp_fc = 0;
  logic [20:0] prev_addr = 0;
  cmd_t cur = '0;

  initial begin
    HCLK = 0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // pix_ready / random abort driver
  initial begin
    bus.pix_ready = 1'b1;
    abort_rnd = 1'b0;
    forever begin
      @(negedge HCLK);
      case (rdy_mode)
        0:       bus.pix_ready = 1'b1;
        1:       bus.pix_ready = ~bus.pix_ready;
        default: bus.pix_ready = ($urandom_range(0, 3) != 0);
      endcase
      abort_rnd = rand_abort_en && ($urandom_range(0, 149) == 0);
    end
  end

  // Monitor / scoreboard for the main DUT
  initial begin
    int r_e, c_e;
    logic ev;
    forever begin
      @(negedge HCLK); #2;
      if (!HRESETn) begin
        exp_q.delete();
        active = 0; load = 0; done_next = 0; prev_stall = 0;
        k = 0; gap_left = 0; exp_fc = 0;
      end else begin
        chk("frame_count", 32'(frame_count), 32'(exp_fc));
        load = 0;
        if (frame_start) begin
          chk("start_while_active", 32'(active), 0);
          if (exp_q.size() == 0) chk("start_without_cmd", 0, 1);
          else begin
            cur = exp_q.pop_front();
            chk("op_at_load", 32'({op_mode, op_sign, op_value, op_thresh}), 32'(cur));
          end
          active = 1; load = 1; k = 0; done_next = 0; gap_left = 0;
        end
        chk("cmd_ready", 32'(bus.cmd_ready), 32'(exp_q.size() < D));
        ev = active && !load && !done_next && (gap_left == 0);
        chk("pix_valid", 32'(bus.pix_valid), 32'(ev));
        chk("hsync", 32'(bus.HSYNC), 32'(ev));
        r_e = k / W;
        c_e = k % W;
        if (bus.pix_valid && ev) begin
          chk("pix_row", 32'(bus.pix_row), r_e);
          chk("pix_col", 32'(bus.pix_col), c_e);
          chk("pix_addr", 32'(bus.pix_addr), 3 * (W * (H - 1 - r_e) + c_e));
          chk("line_end", 32'(bus.line_end), 32'(c_e == W - 1));
          chk("op_cfg", 32'({op_mode, op_sign, op_value, op_thresh}), 32'(cur));
        end
        if (!bus.pix_valid) chk("addr_idle", 32'(bus.pix_addr), 0);
        if (prev_stall) begin
          chk("hold_valid", 32'(bus.pix_valid), 1);
          chk("hold_addr", 32'(bus.pix_addr), 32'(prev_addr));
        end
        if (done_next) begin
          chk("frame_done", 32'(frame_done), 32'(!abort));
          if (!abort) exp_fc = exp_fc + 16'd1;
          active = 0; done_next = 0;
        end else begin
          chk("no_frame_done", 32'(frame_done), 0);
        end
        if (gap_left > 0) gap_left--;
        if (bus.pix_valid && bus.pix_ready && ev && !abort) begin
          k++;
          if (c_e == W - 1) begin
            if (k == W * H) done_next = 1;
            else            gap_left  = HB;
          end
        end
        if (abort && active) begin
          active = 0; done_next = 0; gap_left = 0; k = 0;
        end
        prev_stall = bus.pix_valid && !bus.pix_ready && !abort;
        prev_addr  = bus.pix_addr;
      end
    end
  end

  task automatic push_cmd(input cmd_t c);
    bit acc;
    int tries;
    acc = 0;
    tries = 0;
    while (!acc && tries < 2000) begin
      @(negedge HCLK);
      bus.cmd_valid  = 1'b1;
      bus.cmd_op     = c.op;
      bus.cmd_sign   = c.sign;
      bus.cmd_value  = c.value;
      bus.cmd_thresh = c.thresh;
      acc = bus.cmd_ready;
      @(posedge HCLK); #1;
      if (acc) exp_q.push_back(c);
      tries++;
    end
    bus.cmd_valid = 1'b0;
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge HCLK); #3;
      n++;
    end while ((exp_q.size() != 0 || active || busy) && n < 5000);
    if (n >= 5000) chk("idle_timeout", 0, 1);
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.op     = 2'($urandom_range(0, 3));
    c.sign   = 1'($urandom_range(0, 1));
    c.value  = 8'($urandom);
    c.thresh = 8'($urandom);
    return c;
  endfunction

  initial begin
    cmd_t c;
    int n;
    int exp2 [4];
    exp2 = '{6, 9, 0, 3};
    HRESETn = 0;
    abort_dir = 0;
    abort2 = 0;
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_sign = 0; bus.cmd_value = 0; bus.cmd_thresh = 0;
    bus2.cmd_valid = 0; bus2.cmd_op = 0; bus2.cmd_sign = 0; bus2.cmd_value = 0; bus2.cmd_thresh = 0;
    bus2.pix_ready = 1;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pix_valid", 32'(bus.pix_valid), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_op", 32'({op_mode, op_sign, op_value, op_thresh}), 0);
    #3 HRESETn = 1;

    // Single command, pix_ready high: latency and frame length
    c = '{op: 2'd1, sign: 1'b1, value: 8'd100, thresh: 8'd0};
    push_cmd(c);
    @(negedge HCLK);
    chk("start_not_yet", 32'(frame_start), 0);
    @(negedge HCLK);
    chk("start_latency", 32'(frame_start), 1);
    n = 0;
    do begin @(negedge HCLK); n++; end while (!frame_done && n < 100);
    chk("frame_len", n, 17);
    wait_idle();
    chk("count_after_1", 32'(frame_count), 1);

    // Backpressure: pix_ready toggling
    rdy_mode = 1;
    push_cmd(c);
    wait_idle();
    rdy_mode = 0;

    // Queue full: five back-to-back pushes
    for (int i = 0; i < 5; i++) push_cmd(rand_cmd());
    @(negedge HCLK);
    chk("full_ready_low", 32'(bus.cmd_ready), 0);
    wait_idle();
    chk("count_after_full", 32'(frame_count), 7);

    // Abort at row 1, col 2 with a second command queued
    push_cmd(rand_cmd());
    push_cmd(rand_cmd());
    n = 0;
    do begin @(negedge HCLK); n++; end
      while (!(bus.pix_valid && bus.pix_row == 10'd1 && bus.pix_col == 11'd2) && n < 200);
    chk("abort_reach", 32'(n < 200), 1);
    abort_dir = 1;
    @(negedge HCLK);
    abort_dir = 0;
    chk("abort_idle", 32'(busy), 0);
    chk("abort_count", 32'(frame_count), 7);
    wait_idle();
    chk("count_after_abort", 32'(frame_count), 8);

    // Async reset pulse during HBLANK
    push_cmd(rand_cmd());
    push_cmd(rand_cmd());
    n = 0;
    do begin @(negedge HCLK); n++; end
      while (!(busy && !bus.pix_valid && !frame_start && !frame_done) && n < 200);
    chk("hblank_reach", 32'(n < 200), 1);
    #3 HRESETn = 0;
    #1;
    chk("arst_pix_valid", 32'(bus.pix_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("arst_frame_count", 32'(frame_count), 0);
    chk("arst_op", 32'({op_mode, op_sign, op_value, op_thresh}), 0);
    @(negedge HCLK);
    #3 HRESETn = 1;
    repeat (4) begin
      @(negedge HCLK);
      chk("flushed_idle", 32'(busy), 0);
    end

    // Randomized commands, backpressure and aborts
    rdy_mode = 2;
    rand_abort_en = 1;
    for (int i = 0; i < 25; i++) begin
      push_cmd(rand_cmd());
      repeat ($urandom_range(0, 3)) @(negedge HCLK);
    end
    rand_abort_en = 0;
    wait_idle();
    rdy_mode = 0;

    // Second instance: WIDTH=2, HEIGHT=2, HBLANK=0
    @(negedge HCLK);
    bus2.cmd_valid = 1; bus2.cmd_op = 2'd2;
    @(posedge HCLK); #1;
    bus2.cmd_valid = 0;
    n = 0;
    do begin @(negedge HCLK); n++; end while (!fs2 && n < 20);
    chk("d2_start", 32'(fs2), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      chk("d2_hsync", 32'(bus2.HSYNC), 1);
      chk("d2_addr", 32'(bus2.pix_addr), exp2[i]);
      chk("d2_line_end", 32'(bus2.line_end), i % 2);
    end
    @(negedge HCLK);
    chk("d2_done", 32'(fd2), 1);
    chk("d2_hsync_off", 32'(bus2.HSYNC), 0);
    chk("d2_op", 32'(om2), 2);
    @(negedge HCLK);
    chk("d2_count", 32'(fc2), 1);
    chk("d2_idle", 32'(busy2), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
